sci_alu_op_sequencer: RTL and testbench
=======================================

Name: sci_alu_op_sequencer

Overview:
Synthesizable initiator for the scientific ALU latched interface. It sweeps a programmed opcode range over one operand pair, drives enable/operands/opcode, and waits a settle interval per opcode. It captures result, excep and err into an internal FIFO drained through a valid/ready port. It replaces hand-written stimulus loops when the ALU sits behind clocked logic.

Parameters:
SETTLE_CYCLES, 2, cycles the ALU inputs are held stable before the result is captured (min 1)
FIFO_DEPTH, 8, capture FIFO entries (power of two, min 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a sweep, ignored unless IDLE
op_first  in  4  first opcode of sweep, sampled on start
op_last  in  4  last opcode of sweep, sampled on start
a_bits  in  64  operand a (IEEE-754 double bit pattern), sampled on start
b_bits  in  64  operand b, sampled on start
busy  out  1  high from the cycle after start until return to IDLE
alu_enable  out  1  ALU latch enable
alu_a  out  64  operand a to ALU
alu_b  out  64  operand b to ALU
alu_opcode  out  4  opcode to ALU
alu_result  in  64  ALU result bits
alu_excep  in  1  ALU exception flag
alu_err  in  1  ALU error flag
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer accepts head when res_valid & res_ready
res_opcode  out  4  opcode of head entry
res_data  out  64  result bits of head entry
res_excep  out  1  excep of head entry
res_err  out  1  err of head entry
res_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, alu_enable=0, alu_a=alu_b=0, alu_opcode=0, FIFO empty, res_valid=0, res_* =0, res_count=0.
- States: IDLE, DRIVE, SETTLE, CAPTURE, STALL, DONE.
- IDLE: on start, latch operands and range, set cur_op=op_first, go to DRIVE.
- DRIVE (1 cycle): alu_opcode=cur_op, alu_a/b=latched operands, alu_enable=1, settle counter=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: hold inputs. Decrement counter; at 0 go to CAPTURE.
- CAPTURE: if FIFO not full, push {cur_op, alu_result, alu_excep, alu_err}. Then, if cur_op==op_last, go to DONE; else cur_op+=1 and go to DRIVE. If FIFO is full, go to STALL.
- STALL: hold the ALU inputs and alu_enable. Return to CAPTURE the cycle after the FIFO is no longer full. The push is never dropped.
- DONE (1 cycle): alu_enable=0, then IDLE. alu_a/b/opcode keep their last values.
- Opcode step is 4-bit modulo. If op_last < op_first, the sweep wraps 15->0 and includes both ends. If op_first==op_last, the sweep is one opcode.
- Per-opcode latency start->push with no stall: 1 (IDLE->DRIVE) + 1 + SETTLE_CYCLES + 1 cycles. Full 16-opcode sweep with SETTLE_CYCLES=2 and no stall: 1+16*4+1 = 66 cycles until busy falls.
- FIFO: a push and a pop in the same cycle are both allowed when full, with occupancy unchanged. The CAPTURE-state full test uses occupancy after a same-cycle pop, so a simultaneous pop avoids STALL. A pop on empty is ignored. Read data is combinational from the head. res_valid = (count!=0).
- start while busy is ignored. The FIFO persists across sweeps and is cleared only by reset.
- Reset mid-sweep aborts immediately. FIFO contents are lost and all outputs return to their reset values.

Optional Feature:
SCI_ALU_SEQ_ERR_ABORT_EN
- Defined: if a captured entry has alu_err=1, that entry is still pushed. The sweep then ends through DONE instead of advancing, and a sticky output aborted (1 bit, port present only with the macro) is set. aborted clears on the next accepted start or on reset.
- Undefined: err is only recorded and the sweep always completes. The aborted port does not exist.

Test Plan:
- a=16.0, b=2.0, op_first=0, op_last=15, consumer always ready, SETTLE_CYCLES=2 -> 16 entries with opcodes 0..15 in order, result bits match the ALU model per opcode, busy high for exactly 66 cycles.
- Same sweep with res_ready=0 throughout, FIFO_DEPTH=8 -> 8 entries (opcodes 0..7), state holds in STALL with alu_opcode=8 and alu_enable=1. Releasing res_ready then yields all 16 entries with none lost or duplicated.
- op_first=14, op_last=1 -> 4 entries with opcodes 14,15,0,1.
- FIFO full and a pop on the same CAPTURE cycle -> push accepted, res_count stays at 8, no STALL entered.
- start pulse mid-sweep -> ignored, and the sweep result equals the uninterrupted case. rst_n low mid-sweep -> busy=0, res_valid=0, alu_enable=0 asynchronously.
- Macro defined, ALU model returns err=1 at opcode 5 on a 0..15 sweep -> 6 entries, last with res_err=1, aborted=1, busy falls 2 cycles after that capture.

Source files
------------

// File: rtl/sci_alu_op_sequencer.sv
// +----------------------------------------------------------------------------+
// | sci_alu_op_sequencer: sweeps an opcode range over one operand pair through |
// | the latched ALU into a capture FIFO. Option: SCI_ALU_SEQ_ERR_ABORT_EN. R1.0|
// +----------------------------------------------------------------------------+
`default_nettype none

module sci_alu_op_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [3:0]                    op_first,
   input  logic [3:0]                    op_last,
   input  logic [63:0]                   a_bits,
   input  logic [63:0]                   b_bits,
   output logic                          busy,
   output logic                          alu_enable,
   output logic [63:0]                   alu_a,
   output logic [63:0]                   alu_b,
   output logic [3:0]                    alu_opcode,
   input  logic [63:0]                   alu_result,
   input  logic                          alu_excep,
   input  logic                          alu_err,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [3:0]                    res_opcode,
   output logic [63:0]                   res_data,
   output logic                          res_excep,
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
   output logic                          res_err,
   output logic [$clog2(FIFO_DEPTH):0]   res_count,
   output logic                          aborted
`else
   output logic                          res_err,
   output logic [$clog2(FIFO_DEPTH):0]   res_count
`endif
);

   localparam int              AW          = $clog2(FIFO_DEPTH);
   localparam int              CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [AW:0]     DEPTH_C     = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0]   SETTLE_INIT = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_DRIVE, S_SETTLE, S_CAPTURE, S_STALL, S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     cur_op_q, cur_op_d, last_op_q, last_op_d;
   logic [63:0]    a_q, a_d, b_q, b_d;
   logic [63:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [3:0]     alu_opcode_q, alu_opcode_d;
   logic           alu_enable_q, alu_enable_d;
   logic           busy_q, busy_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic [69:0]    mem_q [FIFO_DEPTH];
   logic           push, pop, full_after_pop, stop;
   logic [69:0]    head;
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
   logic           aborted_q, aborted_d;
`endif

   always_comb begin
      pop            = (count_q != '0) && res_ready;
      // A same-cycle pop frees a slot, so it never forces a stall
      full_after_pop = (count_q == DEPTH_C) && !pop;
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
      stop           = (cur_op_q == last_op_q) || alu_err;
`else
      stop           = (cur_op_q == last_op_q);
`endif
      state_d      = state_q;
      cur_op_d     = cur_op_q;
      last_op_d    = last_op_q;
      a_d          = a_q;
      b_d          = b_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_opcode_d = alu_opcode_q;
      alu_enable_d = alu_enable_q;
      cnt_d        = cnt_q;
      push         = 1'b0;
      busy_d       = (state_q != S_IDLE) || start;
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
      aborted_d    = aborted_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d       = a_bits;
               b_d       = b_bits;
               cur_op_d  = op_first;
               last_op_d = op_last;
               state_d   = S_DRIVE;
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
               aborted_d = 1'b0;
`endif
            end
         end
         S_DRIVE: begin
            alu_opcode_d = cur_op_q;
            alu_a_d      = a_q;
            alu_b_d      = b_q;
            alu_enable_d = 1'b1;
            cnt_d        = SETTLE_INIT;
            state_d      = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == '0) state_d = S_CAPTURE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_CAPTURE: begin
            if (full_after_pop) begin
               state_d = S_STALL;
            end else begin
               push = 1'b1;
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
               if (alu_err) aborted_d = 1'b1;
`endif
               if (stop) begin
                  state_d = S_DONE;
               end else begin
                  cur_op_d = cur_op_q + 4'd1;
                  state_d  = S_DRIVE;
               end
            end
         end
         S_STALL: begin
            if (count_q != DEPTH_C) state_d = S_CAPTURE;
         end
         S_DONE: begin
            alu_enable_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cur_op_q     <= '0;
         last_op_q    <= '0;
         a_q          <= '0;
         b_q          <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_opcode_q <= '0;
         alu_enable_q <= 1'b0;
         busy_q       <= 1'b0;
         cnt_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
         aborted_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cur_op_q     <= cur_op_d;
         last_op_q    <= last_op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_opcode_q <= alu_opcode_d;
         alu_enable_q <= alu_enable_d;
         busy_q       <= busy_d;
         cnt_q        <= cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
         aborted_q    <= aborted_d;
`endif
      end
   end

   // Storage needs no reset: outputs are masked while the FIFO is empty
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cur_op_q, alu_result, alu_excep, alu_err};
   end

   assign head       = mem_q[rd_ptr_q];
   assign res_valid  = (count_q != '0);
   assign {res_opcode, res_data, res_excep, res_err} = res_valid ? head : 70'd0;
   assign res_count  = count_q;
   assign busy       = busy_q;
   assign alu_enable = alu_enable_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_opcode_q;
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
   assign aborted    = aborted_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sci_alu_op_sequencer.sv
// Bench for sci_alu_op_sequencer: table sweeps, corner sequences and random sweeps
// checked against a queue-based model of the sweep and capture order.
`default_nettype none

module tb_sci_alu_op_sequencer;
   localparam int SETTLE = 2;
   localparam int DEPTH  = 8;
   localparam logic [63:0] D16 = 64'h4030000000000000;
   localparam logic [63:0] D2  = 64'h4000000000000000;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, res_ready = 1'b0;
   logic [3:0] op_first = '0, op_last = '0;
   logic [63:0] a_bits = '0, b_bits = '0;
   logic busy, alu_enable, alu_excep, alu_err, res_valid, res_excep, res_err;
   logic [63:0] alu_a, alu_b, alu_result, res_data;
   logic [3:0] alu_opcode, res_opcode;
   logic [$clog2(DEPTH):0] res_count;
   bit err_mode = 1'b0;
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
   logic aborted;
`endif

   int checks = 0, errors = 0, popped = 0, busy_cycles = 0;
   logic [69:0] exp_q [$];

   sci_alu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_first(op_first), .op_last(op_last),
      .a_bits(a_bits), .b_bits(b_bits), .busy(busy), .alu_enable(alu_enable),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
      .alu_excep(alu_excep), .alu_err(alu_err), .res_valid(res_valid), .res_ready(res_ready),
      .res_opcode(res_opcode), .res_data(res_data), .res_excep(res_excep), .res_err(res_err),
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
      .res_count(res_count), .aborted(aborted)
`else
      .res_count(res_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [65:0] alu_fn(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input bit em);
      logic [63:0] r;
      r = (a + (b << op[1:0])) ^ {op, 60'h0};
      return {r, op[1] & op[0], em && (op == 4'd5)};
   endfunction

   always_comb {alu_result, alu_excep, alu_err} = alu_fn(alu_opcode, alu_a, alu_b, err_mode);

   // Expected capture list: every opcode from first to last modulo 16
   task automatic load_model(input logic [3:0] first, input logic [3:0] last,
                             input logic [63:0] a, input logic [63:0] b, input bit em,
                             output int n);
      logic [3:0] op;
      logic [65:0] r;
      op = first;
      n  = 0;
      for (int i = 0; i < 16; i++) begin
         r = alu_fn(op, a, b, em);
         exp_q.push_back({op, r});
         n++;
         if (op == last) break;
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
         if (r[0]) break;
`endif
         op = op + 4'd1;
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: observe at the falling edge, return 1 time unit after the rising edge
   task automatic step();
      logic [69:0] e;
      @(negedge clk);
      if (busy) busy_cycles++;
      if (res_valid && res_ready) begin
         checks++;
         popped++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got %0h expected none",
                     {res_opcode, res_data, res_excep, res_err});
         end else begin
            e = exp_q.pop_front();
            if ({res_opcode, res_data, res_excep, res_err} !== e) begin
               errors++;
               $display("FAIL pop_data: got %0h expected %0h",
                        {res_opcode, res_data, res_excep, res_err}, e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_sweep(input logic [3:0] f, input logic [3:0] l, input logic [63:0] a,
                              input logic [63:0] b, input bit em, output int n);
      load_model(f, l, a, b, em, n);
      op_first = f; op_last = l; a_bits = a; b_bits = b; err_mode = em;
      busy_cycles = 0;
      popped = 0;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max, input bit rnd);
      int k = 0;
      while (busy && k < max) begin
         if (rnd) res_ready = 1'($urandom_range(0, 1));
         step();
         k++;
      end
      chk("busy_timeout", {63'd0, busy}, 64'd0);
   endtask

   task automatic drain();
      int k = 0;
      res_ready = 1'b1;
      while (res_count != 0 && k < 64) begin
         step();
         k++;
      end
      chk("drain_timeout", 64'(res_count), 64'd0);
   endtask

   typedef struct {
      logic [3:0]  first;
      logic [3:0]  last;
      logic [63:0] a;
      logic [63:0] b;
      bit          errm;
      int          exp_n;
      int          exp_busy;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int n;
      vecs[0] = '{4'd0,  4'd15, D16, D2, 1'b0, 16, 66};
      vecs[1] = '{4'd14, 4'd1,  D16, D2, 1'b0, 4,  18};
      vecs[2] = '{4'd7,  4'd7,  64'h0123456789abcdef, D2, 1'b0, 1, 6};
      vecs[3] = '{4'd15, 4'd0,  64'hfff0000000000000, 64'h3ff0000000000000, 1'b0, 2, 10};
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
      vecs[4] = '{4'd3,  4'd9,  D2, D16, 1'b1, 3,  14};
`else
      vecs[4] = '{4'd3,  4'd9,  D2, D16, 1'b1, 7,  30};
`endif
      vecs[5] = '{4'd5,  4'd5,  D16, D16, 1'b1, 1, 6};

      repeat (3) step();
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_enable", {63'd0, alu_enable}, 64'd0);
      chk("rst_alu_a", alu_a, 64'd0);
      chk("rst_alu_b", alu_b, 64'd0);
      chk("rst_opcode", 64'(alu_opcode), 64'd0);
      chk("rst_valid", {63'd0, res_valid}, 64'd0);
      chk("rst_data", res_data, 64'd0);
      chk("rst_count", 64'(res_count), 64'd0);
`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
      chk("rst_aborted", {63'd0, aborted}, 64'd0);
`endif
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 6; i++) begin
         res_ready = 1'b1;
         start_sweep(vecs[i].first, vecs[i].last, vecs[i].a, vecs[i].b, vecs[i].errm, n);
         wait_idle(200, 1'b0);
         drain();
         chk($sformatf("vec%0d_pops", i), 64'(popped), 64'(vecs[i].exp_n));
         chk($sformatf("vec%0d_busy", i), 64'(busy_cycles), 64'(vecs[i].exp_busy));
         chk($sformatf("vec%0d_left", i), 64'(exp_q.size()), 64'd0);
      end

      // Consumer stalled: FIFO fills with 0..7, sequencer holds opcode 8
      res_ready = 1'b0;
      start_sweep(4'd0, 4'd15, D16, D2, 1'b0, n);
      repeat (50) step();
      chk("stall_count", 64'(res_count), 64'(DEPTH));
      chk("stall_opcode", 64'(alu_opcode), 64'd8);
      chk("stall_enable", {63'd0, alu_enable}, 64'd1);
      chk("stall_busy", {63'd0, busy}, 64'd1);
      chk("stall_alu_a", alu_a, D16);
      res_ready = 1'b1;
      wait_idle(300, 1'b0);
      drain();
      chk("stall_pops", 64'(popped), 64'd16);
      chk("stall_left", 64'(exp_q.size()), 64'd0);

      // Full FIFO with a pop in the same capture cycle: push accepted, no stall
      res_ready = 1'b0;
      start_sweep(4'd0, 4'd9, D2, D16, 1'b0, n);
      repeat (35) step();
      chk("fullpop_pre_count", 64'(res_count), 64'(DEPTH));
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("fullpop_count", 64'(res_count), 64'(DEPTH));
      step();
      chk("fullpop_next_op", 64'(alu_opcode), 64'd9);
      res_ready = 1'b1;
      wait_idle(300, 1'b0);
      drain();
      chk("fullpop_pops", 64'(popped), 64'd10);

      // A second start mid-sweep is ignored
      res_ready = 1'b1;
      start_sweep(4'd2, 4'd6, D16, D2, 1'b0, n);
      repeat (7) step();
      op_first = 4'd0; op_last = 4'd15; a_bits = 64'hdead; start = 1'b1;
      step();
      start = 1'b0;
      wait_idle(200, 1'b0);
      drain();
      chk("midstart_pops", 64'(popped), 64'd5);
      chk("midstart_busy", 64'(busy_cycles), 64'd22);

      // Asynchronous reset in the middle of a sweep
      res_ready = 1'b0;
      start_sweep(4'd0, 4'd15, D16, D2, 1'b0, n);
      repeat (10) step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_valid", {63'd0, res_valid}, 64'd0);
      chk("arst_enable", {63'd0, alu_enable}, 64'd0);
      chk("arst_count", 64'(res_count), 64'd0);
      exp_q.delete();
      repeat (2) step();
      rst_n = 1'b1;
      step();

`ifdef SCI_ALU_SEQ_ERR_ABORT_EN
      res_ready = 1'b1;
      start_sweep(4'd0, 4'd15, D16, D2, 1'b1, n);
      wait_idle(200, 1'b0);
      drain();
      chk("abort_pops", 64'(popped), 64'd6);
      chk("abort_busy", 64'(busy_cycles), 64'd26);
      chk("abort_flag", {63'd0, aborted}, 64'd1);
      start_sweep(4'd7, 4'd7, D16, D2, 1'b1, n);
      chk("abort_clear", {63'd0, aborted}, 64'd0);
      wait_idle(200, 1'b0);
      drain();
      chk("abort_after_pops", 64'(popped), 64'd1);
`endif

      // Random sweeps with a randomly stalling consumer
      for (int r = 0; r < 8; r++) begin
         start_sweep(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     {$urandom, $urandom}, {$urandom, $urandom}, bit'($urandom_range(0, 1)), n);
         wait_idle(2000, 1'b1);
         drain();
         chk($sformatf("rand%0d_pops", r), 64'(popped), 64'(n));
         chk($sformatf("rand%0d_left", r), 64'(exp_q.size()), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
